// File: rtl/multi_counter_selector.sv
// Channel selector and saturating step counter with BCD 7-segment digits and an LED progress bar.
// Define CNT_DEBOUNCE_EN to add a stable-level debounce filter on every button.
module multi_counter_selector #(
   parameter int unsigned         NUM_CH          = 3,
   parameter logic [8*NUM_CH-1:0] STEPS           = {8'd10, 8'd4, 8'd1},
   parameter int unsigned         LIMIT           = 999,
   parameter int unsigned         TICK_DIV        = 25_000_000,
   parameter int unsigned         DEBOUNCE_CYCLES = 250_000,
   localparam int unsigned        CHW             = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
   localparam int unsigned        CW              = $clog2(LIMIT + 1)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           next_btn,
   input  logic           select_btn,
   input  logic           step_btn,
   input  logic           mode_manual,
   output logic [CHW-1:0] ch_idx,
   output logic           busy,
   output logic           mode_q,
   output logic           done,
   output logic [CW-1:0]  count,
   output logic [6:0]     seg_hund,
   output logic [6:0]     seg_tens,
   output logic [6:0]     seg_units,
   output logic [4:0]     led
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   // Sum width must hold count plus a full 8-bit step without wrapping.
   localparam int unsigned SW = (CW + 1 > 9) ? CW + 1 : 9;
   localparam int unsigned LW = CW + 3;

   localparam logic [6:0] SegZero = 7'b1000000;

   typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

   // ------------------------------------------------------------------
   // Button conditioning: bit 0 next, bit 1 select, bit 2 step
   // ------------------------------------------------------------------
   logic [2:0] btn_raw;
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;
   logic [2:0] lvl;
   logic [2:0] prev_q;
   logic [2:0] pulse;
   logic       next_p;
   logic       sel_p;
   logic       step_p;

   assign btn_raw = {step_btn, select_btn, next_btn};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         prev_q  <= lvl;
      end
   end

`ifdef CNT_DEBOUNCE_EN
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

   for (genvar b = 0; b < 3; b++) begin : g_debounce
      logic [DBW-1:0] db_cnt_q;
      logic           db_lvl_q;

      // The filtered level flips only after the input disagrees for a full window.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
         end else if (sync2_q[b] == db_lvl_q) begin
            db_cnt_q <= '0;
         end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES)) begin
            db_cnt_q <= '0;
            db_lvl_q <= sync2_q[b];
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
      end

      assign lvl[b] = db_lvl_q;
   end
`else
   logic [2:0] lvl_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lvl_q <= '0;
      end else begin
         lvl_q <= sync2_q;
      end
   end

   assign lvl = lvl_q;
`endif

   assign pulse  = lvl & ~prev_q;
   assign next_p = pulse[0];
   assign sel_p  = pulse[1];
   assign step_p = pulse[2];

   // ------------------------------------------------------------------
   // Control FSM and counter
   // ------------------------------------------------------------------
   state_e         state_q, state_d;
   logic [CHW-1:0] ch_q, ch_d;
   logic [CW-1:0]  count_q, count_d;
   logic           mode_lat_q, mode_lat_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [7:0]     step;
   logic           tick;
   logic           inc;
   logic [SW-1:0]  sum;

   always_comb begin
      step = 8'd1;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_q == CHW'(k)) step = STEPS[8*k +: 8];
      end
   end

   assign tick = (presc_q == PW'(TICK_DIV - 1));
   assign inc  = mode_lat_q ? step_p : tick;
   assign sum  = SW'(count_q) + SW'(step);

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      count_d    = count_q;
      mode_lat_d = mode_lat_q;
      presc_d    = presc_q;
      unique case (state_q)
         StIdle: begin
            // Select takes priority over a coincident next.
            if (sel_p) begin
               count_d    = '0;
               mode_lat_d = mode_manual;
               presc_d    = '0;
               state_d    = StRun;
            end else if (next_p) begin
               ch_d = (ch_q == CHW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
            end
         end
         StRun: begin
            if (mode_lat_q || tick) begin
               presc_d = '0;
            end else begin
               presc_d = presc_q + 1'b1;
            end
            // Abort beats an increment arriving in the same cycle.
            if (sel_p) begin
               state_d = StIdle;
            end else if (inc) begin
               if (sum >= SW'(LIMIT)) begin
                  count_d = CW'(LIMIT);
                  state_d = StFinish;
               end else begin
                  count_d = sum[CW-1:0];
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Display path: binary to BCD, 7-segment decode, progress bar
   // ------------------------------------------------------------------
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   logic [9:0]    bin;
   logic [11:0]   bcd;
   logic [LW-1:0] five_cnt;
   logic [4:0]    led_d;
   logic [6:0]    seg_hund_q, seg_tens_q, seg_units_q;
   logic [4:0]    led_q;

   // Shift-add-3 conversion; count never exceeds 999 so 10 input bits suffice.
   always_comb begin
      bin = 10'(count_q);
      bcd = '0;
      for (int i = 9; i >= 0; i--) begin
         if (bcd[3:0] >= 4'd5)  bcd[3:0]  = bcd[3:0] + 4'd3;
         if (bcd[7:4] >= 4'd5)  bcd[7:4]  = bcd[7:4] + 4'd3;
         if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
         bcd = {bcd[10:0], bin[i]};
      end
   end

   always_comb begin
      five_cnt = (LW'(count_q) << 2) + LW'(count_q);
      led_d    = '0;
      for (int k = 0; k < 5; k++) begin
         led_d[k] = (five_cnt >= LW'((k + 1) * LIMIT));
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         ch_q        <= '0;
         count_q     <= '0;
         mode_lat_q  <= 1'b0;
         presc_q     <= '0;
         seg_hund_q  <= SegZero;
         seg_tens_q  <= SegZero;
         seg_units_q <= SegZero;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         count_q     <= count_d;
         mode_lat_q  <= mode_lat_d;
         presc_q     <= presc_d;
         seg_hund_q  <= seg7(bcd[11:8]);
         seg_tens_q  <= seg7(bcd[7:4]);
         seg_units_q <= seg7(bcd[3:0]);
         led_q       <= led_d;
      end
   end

   assign ch_idx    = ch_q;
   assign busy      = (state_q == StRun);
   assign done      = (state_q == StFinish);
   assign mode_q    = mode_lat_q;
   assign count     = count_q;
   assign seg_hund  = seg_hund_q;
   assign seg_tens  = seg_tens_q;
   assign seg_units = seg_units_q;
   assign led       = led_q;

endmodule

// File: tb/tb_multi_counter_selector.sv
// Bench for multi_counter_selector: directed scenarios plus random button traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_multi_counter_selector;

   localparam int unsigned NUM_CH   = 3;
   localparam int unsigned LIMIT    = 20;
   localparam int unsigned TICK_DIV = 4;
   localparam logic [23:0] STEPS    = {8'd10, 8'd4, 8'd1};

   logic       clk;
   logic       reset_n;
   logic       next_btn;
   logic       select_btn;
   logic       step_btn;
   logic       mode_manual;
   logic [1:0] ch_idx;
   logic       busy;
   logic       mode_q;
   logic       done;
   logic [4:0] count;
   logic [6:0] seg_hund;
   logic [6:0] seg_tens;
   logic [6:0] seg_units;
   logic [4:0] led;

   multi_counter_selector #(
      .NUM_CH          (NUM_CH),
      .STEPS           (STEPS),
      .LIMIT           (LIMIT),
      .TICK_DIV        (TICK_DIV),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .next_btn    (next_btn),
      .select_btn  (select_btn),
      .step_btn    (step_btn),
      .mode_manual (mode_manual),
      .ch_idx      (ch_idx),
      .busy        (busy),
      .mode_q      (mode_q),
      .done        (done),
      .count       (count),
      .seg_hund    (seg_hund),
      .seg_tens    (seg_tens),
      .seg_units   (seg_units),
      .led         (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;
   int done_seen;

   int steps_tab [3] = '{1, 4, 10};
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // Reference model: 0 idle, 1 running, 2 finishing
   int       m_state;
   int       m_ch;
   int       m_count;
   int       m_disp;
   int       m_elapsed;
   bit       m_mode;
   bit [4:0] h_next, h_sel, h_step;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp,
                  $time);
      end
   endtask

   task automatic model_reset();
      m_state   = 0;
      m_ch      = 0;
      m_count   = 0;
      m_disp    = 0;
      m_elapsed = 0;
      m_mode    = 1'b0;
      h_next    = '0;
      h_sel     = '0;
      h_step    = '0;
   endtask

   // A pin level first seen at edge n becomes an action at edge n+3.
   task automatic model_step();
      bit pn, ps, pt, ev;
      if (!reset_n) begin
         model_reset();
         return;
      end
      m_disp = m_count;
      h_next = {h_next[3:0], next_btn};
      h_sel  = {h_sel[3:0], select_btn};
      h_step = {h_step[3:0], step_btn};
      pn = h_next[3] & ~h_next[4];
      ps = h_sel[3] & ~h_sel[4];
      pt = h_step[3] & ~h_step[4];
      case (m_state)
         0: begin
            if (ps) begin
               m_count   = 0;
               m_mode    = mode_manual;
               m_elapsed = 0;
               m_state   = 1;
            end else if (pn) begin
               m_ch = (m_ch + 1) % NUM_CH;
            end
         end
         1: begin
            if (ps) begin
               m_state = 0;
            end else begin
               m_elapsed++;
               ev = m_mode ? pt : ((m_elapsed % TICK_DIV) == 0);
               if (ev) begin
                  if (m_count + steps_tab[m_ch] >= LIMIT) begin
                     m_count = LIMIT;
                     m_state = 2;
                  end else begin
                     m_count = m_count + steps_tab[m_ch];
                  end
               end
            end
         end
         default: m_state = 0;
      endcase
   endtask

   task automatic check_outputs();
      logic [4:0] exp_led;
      for (int k = 0; k < 5; k++) exp_led[k] = (5 * m_disp >= (k + 1) * int'(LIMIT));
      check_eq("ch_idx", ch_idx, m_ch);
      check_eq("busy", busy, m_state == 1);
      check_eq("done", done, m_state == 2);
      check_eq("mode_q", mode_q, m_mode);
      check_eq("count", count, m_count);
      check_eq("seg_hund", seg_hund, seg_tab[m_disp / 100]);
      check_eq("seg_tens", seg_tens, seg_tab[(m_disp / 10) % 10]);
      check_eq("seg_units", seg_units, seg_tab[m_disp % 10]);
      check_eq("led", led, exp_led);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
      if (done === 1'b1) done_seen++;
   endtask

   task automatic set_btn(input int which, input bit val);
      case (which)
         0:       next_btn   = val;
         1:       select_btn = val;
         default: step_btn   = val;
      endcase
   endtask

   task automatic press(input int which, input int hi, input int lo);
      set_btn(which, 1'b1);
      repeat (hi) cycle();
      set_btn(which, 1'b0);
      repeat (lo) cycle();
   endtask

   task automatic wait_idle(input int bound, input string tag);
      for (int i = 0; i < bound && m_state != 0; i++) cycle();
      check_eq(tag, busy, 1'b0);
   endtask

   task automatic wait_count(input int target, input int bound, input string tag);
      for (int i = 0; i < bound && !(m_state == 1 && m_count == target); i++) cycle();
      check_eq(tag, count, target);
   endtask

   // Reset is dropped between clock edges and must act before the next edge.
   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      cycle();
      cycle();
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached with checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int prob_hi [3] = '{3, 8, 2};
      int hold [3]    = '{0, 0, 0};

      n_checks    = 0;
      n_fail      = 0;
      done_seen   = 0;
      next_btn    = 1'b0;
      select_btn  = 1'b0;
      step_btn    = 1'b0;
      mode_manual = 1'b0;
      reset_n     = 1'b0;
      model_reset();
      repeat (3) cycle();
      reset_n = 1'b1;

      // Quiet period after reset
      repeat (100) cycle();
      check_eq("quiet_count", count, 0);
      check_eq("quiet_seg_units", seg_units, 7'b1000000);
      check_eq("quiet_led", led, 0);

      // Channel browsing with wrap
      press(0, 5, 5);
      check_eq("next_1", ch_idx, 1);
      press(0, 5, 5);
      check_eq("next_2", ch_idx, 2);
      press(0, 5, 5);
      check_eq("next_wrap", ch_idx, 0);

      // NEXT and SELECT together: select wins, auto run on channel 0
      mode_manual = 1'b0;
      done_seen   = 0;
      next_btn    = 1'b1;
      select_btn  = 1'b1;
      repeat (5) cycle();
      next_btn    = 1'b0;
      select_btn  = 1'b0;
      check_eq("both_busy", busy, 1);
      check_eq("both_ch", ch_idx, 0);
      wait_idle(200, "ch0_end_busy");
      check_eq("ch0_final", count, 20);
      check_eq("ch0_done_pulses", done_seen, 1);

      // Auto run on channel 1 (step 4)
      press(0, 5, 5);
      check_eq("sel_ch1", ch_idx, 1);
      done_seen = 0;
      press(1, 5, 0);
      wait_idle(100, "ch1_end_busy");
      repeat (3) cycle();
      check_eq("ch1_count", count, 20);
      check_eq("ch1_done_pulses", done_seen, 1);
      check_eq("ch1_hund", seg_hund, 7'b1000000);
      check_eq("ch1_tens", seg_tens, 7'b0100100);
      check_eq("ch1_units", seg_units, 7'b1000000);
      check_eq("ch1_led", led, 5'b11111);

      // Manual run on channel 2 (step 10)
      press(0, 5, 5);
      check_eq("sel_ch2", ch_idx, 2);
      mode_manual = 1'b1;
      done_seen   = 0;
      press(1, 5, 5);
      check_eq("man_mode_q", mode_q, 1);
      press(2, 20, 5);
      check_eq("man_first", count, 10);
      check_eq("man_first_busy", busy, 1);
      press(2, 5, 5);
      check_eq("man_second", count, 20);
      check_eq("man_second_busy", busy, 0);
      check_eq("man_done_pulses", done_seen, 1);
      press(2, 5, 5);
      check_eq("man_third_ignored", count, 20);
      check_eq("man_third_done", done_seen, 1);

      // Abort on channel 0 at count 3, lands on the same edge as a tick
      press(0, 5, 5);
      check_eq("sel_ch0", ch_idx, 0);
      mode_manual = 1'b0;
      done_seen   = 0;
      press(1, 5, 0);
      mode_manual = 1'b1;
      wait_count(3, 60, "abort_reach3");
      check_eq("abort_mode_q", mode_q, 0);
      mode_manual = 1'b0;
      press(1, 5, 5);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_count", count, 3);
      check_eq("abort_no_done", done_seen, 0);

      // Asynchronous reset mid-run at count 12 on channel 1
      press(0, 5, 5);
      press(1, 5, 0);
      wait_count(12, 80, "rst_reach12");
      check_eq("rst_pre_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_eq("rst_count", count, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ch", ch_idx, 0);
      check_eq("rst_hund", seg_hund, 7'b1000000);
      check_eq("rst_tens", seg_tens, 7'b1000000);
      check_eq("rst_units", seg_units, 7'b1000000);
      check_eq("rst_led", led, 0);
      cycle();
      cycle();
      reset_n = 1'b1;

      // Random button traffic
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               set_btn(b, $urandom_range(0, prob_hi[b] - 1) == 0);
               hold[b] = $urandom_range(1, 10);
            end else begin
               hold[b]--;
            end
         end
         if ($urandom_range(0, 30) == 0) mode_manual = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 999) == 0) async_reset();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
